program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 512, meaning the word capacity of each memory (9-bit address space).
REQ-002 SHALL have parameter CMD_IRAM, default 8'hA1, meaning the command byte for an IRAM load.
REQ-003 SHALL have parameter CMD_DRAM, default 8'hA2, meaning the command byte for a DRAM load.
REQ-004 SHALL have parameter CMD_RUN, default 8'hA5, meaning the command byte that starts the processor.
REQ-005 SHALL have parameter CMD_HALT, default 8'hA0, meaning the command byte that stops the processor.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port rx_valid, input, 1 bit: one-cycle strobe meaning rx_byte is valid.
REQ-009 SHALL have port rx_byte, input, 8 bits: the received serial byte.
REQ-010 SHALL have port start, output, 1 bit: processor run enable.
REQ-011 SHALL have port start_2, output, 1 bit: IRAM external-access enable.
REQ-012 SHALL have port start_3, output, 1 bit: DRAM external-access enable.
REQ-013 SHALL have port iram_write_ext, output, 1 bit: IRAM write request.
REQ-014 SHALL have port dram_write_ext, output, 1 bit: DRAM write request.
REQ-015 SHALL have port addr_ext, output, 9 bits: the external write address.
REQ-016 SHALL have port Data_in_ins, output, 16 bits: the IRAM write word.
REQ-017 SHALL have port Data_in_dram, output, 16 bits: the DRAM write word.
REQ-018 SHALL have port busy, output, 1 bit: high whenever the FSM is in any state other than IDLE or RUN.
REQ-019 SHALL have port load_ok, output, 1 bit: one-cycle pulse on a successful load.
REQ-020 SHALL have port error, output, 1 bit: sticky protocol-error flag.

Function
REQ-021 SHALL implement FSM states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WR1, WR2, CHK, RUN; each transition listed below occurs only on a cycle with rx_valid=1, unless stated otherwise.
REQ-022 In IDLE, SHALL decode the byte as follows, and SHALL clear error on any command byte received in IDLE:
  - CMD_IRAM or CMD_DRAM: latch the target memory and go to LEN_HI.
  - CMD_RUN: go to RUN.
  - CMD_HALT: stay in IDLE.
  - any other value: set error and stay in IDLE.
REQ-023 SHALL take the word count N big-endian from the LEN_HI and LEN_LO bytes; N=0 or N>MAX_WORDS SHALL set error and return to IDLE.
REQ-024 SHALL assemble each data word big-endian from the DATA_HI and DATA_LO bytes, XOR every data byte into an 8-bit checksum initialised to 0 at the command, and go to WR1 after DATA_LO.
REQ-025 In WR1 (one cycle), SHALL drive the selected start_2/start_3 = 1, the matching *_write_ext = 1, addr_ext = word index, and the word on the matching data port.
REQ-026 In WR2 (one cycle), SHALL drive the same start_x = 1 with *_write_ext = 0, holding addr_ext and data unchanged.
REQ-027 SHALL hold Data_in_ins and Data_in_dram until the next write to the same memory (the downstream IRAM samples Data_in_ins one cycle after the strobe).
REQ-028 After WR2, SHALL increment the index and go to DATA_HI if index < N, otherwise to CHK; the index SHALL start at 0 and not wrap, since the count limit ends the load first.
REQ-029 In CHK, SHALL compare the received byte with the running checksum:
  - match: pulse load_ok and go to IDLE.
  - mismatch: set error and go to IDLE; already-written words remain in memory.
REQ-030 If rx_valid is asserted during WR1 or WR2, SHALL set error, drop the byte, complete WR2 and then go to IDLE.
REQ-031 In RUN, SHALL hold start=1 and start_2=start_3=0:
  - CMD_HALT: start=0 from the next cycle and go to IDLE.
  - any other byte: set error and stay in RUN.
REQ-032 start_2, start_3 and the write strobes SHALL be 0 in every state except WR1/WR2; start SHALL be 1 only in RUN.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 When reset_n=0 at a clock edge, SHALL go to IDLE; all outputs, N, the index and the checksum SHALL become 0; no write strobe is issued during reset.
REQ-035 reset_n low mid-load (including in WR1) SHALL abort without finishing the WR2 cycle; memory contents are then undefined only at that one address.

Structure
REQ-036 Command codes, the state enum, MAX_WORDS and the address width (9) SHALL live in the shared package loader_pkg.
REQ-037 SHALL be a single module with no sub-module; the checksum and byte assembly are inline.

Verification
REQ-038 Bytes A1 00 02 12 34 AB CD 40 -> IRAM writes 0x1234@0 and 0xABCD@1, each WR1 then WR2; load_ok pulses; error=0.
REQ-039 Bytes A2 00 01 BE EF 00 (bad checksum) -> DRAM 0xBEEF@0 written; error=1; no load_ok pulse.
REQ-040 Bytes A1 02 01 -> error=1, return to IDLE, no writes issued.
REQ-041 A5 then A0 -> start=1 from the cycle after A5 until the cycle after A0; a 0x77 byte received in RUN sets error while start stays 1.
REQ-042 rx_valid during WR1 -> error=1, WR2 still completes, then IDLE.
REQ-043 reset_n=0 during DATA_LO -> next cycle: all outputs 0, state IDLE; a new load A1 00 01 00 05 05 then succeeds.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: command codes, sizes
// and the loader state encoding.
package loader_pkg;

    localparam int          ADDR_W        = 9;
    localparam int          DEF_MAX_WORDS = 512;
    localparam logic [7:0]  DEF_CMD_IRAM  = 8'hA1;
    localparam logic [7:0]  DEF_CMD_DRAM  = 8'hA2;
    localparam logic [7:0]  DEF_CMD_RUN   = 8'hA5;
    localparam logic [7:0]  DEF_CMD_HALT  = 8'hA0;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WR1,
        WR2,
        CHK,
        RUN
    } state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream loader: decodes commands, writes checksummed word blocks into
// IRAM or DRAM through a two-cycle external write, and gates processor run.
module program_loader
    import loader_pkg::*;
#(
    parameter int         MAX_WORDS = DEF_MAX_WORDS,
    parameter logic [7:0] CMD_IRAM  = DEF_CMD_IRAM,
    parameter logic [7:0] CMD_DRAM  = DEF_CMD_DRAM,
    parameter logic [7:0] CMD_RUN   = DEF_CMD_RUN,
    parameter logic [7:0] CMD_HALT  = DEF_CMD_HALT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              start,
    output logic              start_2,
    output logic              start_3,
    output logic              iram_write_ext,
    output logic              dram_write_ext,
    output logic [ADDR_W-1:0] addr_ext,
    output logic [15:0]       Data_in_ins,
    output logic [15:0]       Data_in_dram,
    output logic              busy,
    output logic              load_ok,
    output logic              error
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t     state_reg;
    logic       target_reg;
    logic [7:0] byte_hi_reg;
    logic [9:0] n_reg;
    logic [9:0] idx_reg;
    logic [7:0] csum_reg;
    logic       abort_reg;

    // The high-byte register serves both the length and the data words.
    logic [15:0] word_next;
    logic [9:0]  idx_next;
    assign word_next = {byte_hi_reg, rx_byte};
    assign idx_next  = idx_reg + 10'd1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            target_reg     <= 1'b0;
            byte_hi_reg    <= 8'h00;
            n_reg          <= 10'd0;
            idx_reg        <= 10'd0;
            csum_reg       <= 8'h00;
            abort_reg      <= 1'b0;
            start          <= 1'b0;
            start_2        <= 1'b0;
            start_3        <= 1'b0;
            iram_write_ext <= 1'b0;
            dram_write_ext <= 1'b0;
            addr_ext       <= '0;
            Data_in_ins    <= 16'h0000;
            Data_in_dram   <= 16'h0000;
            busy           <= 1'b0;
            load_ok        <= 1'b0;
            error          <= 1'b0;
        end else begin
            load_ok <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_byte == CMD_IRAM || rx_byte == CMD_DRAM) begin
                            target_reg <= (rx_byte == CMD_DRAM);
                            csum_reg   <= 8'h00;
                            idx_reg    <= 10'd0;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            state_reg  <= LEN_HI;
                        end else if (rx_byte == CMD_RUN) begin
                            error     <= 1'b0;
                            start     <= 1'b1;
                            state_reg <= RUN;
                        end else if (rx_byte == CMD_HALT) begin
                            error <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LEN_HI: begin
                    if (rx_valid) begin
                        byte_hi_reg <= rx_byte;
                        state_reg   <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (rx_valid) begin
                        if (word_next == 16'd0 || word_next > MAX_LEN) begin
                            error     <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            n_reg     <= word_next[9:0];
                            state_reg <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (rx_valid) begin
                        byte_hi_reg <= rx_byte;
                        csum_reg    <= csum_reg ^ rx_byte;
                        state_reg   <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (rx_valid) begin
                        csum_reg  <= csum_reg ^ rx_byte;
                        addr_ext  <= idx_reg[ADDR_W-1:0];
                        abort_reg <= 1'b0;
                        if (target_reg) begin
                            start_3        <= 1'b1;
                            dram_write_ext <= 1'b1;
                            Data_in_dram   <= word_next;
                        end else begin
                            start_2        <= 1'b1;
                            iram_write_ext <= 1'b1;
                            Data_in_ins    <= word_next;
                        end
                        state_reg <= WR1;
                    end
                end
                WR1: begin
                    iram_write_ext <= 1'b0;
                    dram_write_ext <= 1'b0;
                    if (rx_valid) begin
                        error     <= 1'b1;
                        abort_reg <= 1'b1;
                    end
                    state_reg <= WR2;
                end
                WR2: begin
                    start_2 <= 1'b0;
                    start_3 <= 1'b0;
                    idx_reg <= idx_next;
                    if (rx_valid) begin
                        error <= 1'b1;
                    end
                    // A byte arriving mid-write is dropped and the load abandoned.
                    if (rx_valid || abort_reg) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (idx_next < n_reg) begin
                        state_reg <= DATA_HI;
                    end else begin
                        state_reg <= CHK;
                    end
                end
                CHK: begin
                    if (rx_valid) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                        if (rx_byte == csum_reg) begin
                            load_ok <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rx_valid) begin
                        if (rx_byte == CMD_HALT) begin
                            start     <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    start     <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte-stream vectors with hand-computed
// write traces, plus run/halt, mid-write byte and mid-load reset sequences.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        start, start_2, start_3;
    logic        iram_write_ext, dram_write_ext;
    logic [8:0]  addr_ext;
    logic [15:0] Data_in_ins, Data_in_dram;
    logic        busy, load_ok, error;

    always #5 clock = ~clock;

    program_loader dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rx_valid       (rx_valid),
        .rx_byte        (rx_byte),
        .start          (start),
        .start_2        (start_2),
        .start_3        (start_3),
        .iram_write_ext (iram_write_ext),
        .dram_write_ext (dram_write_ext),
        .addr_ext       (addr_ext),
        .Data_in_ins    (Data_in_ins),
        .Data_in_dram   (Data_in_dram),
        .busy           (busy),
        .load_ok        (load_ok),
        .error          (error)
    );

    typedef struct {
        int          nb;
        logic [63:0] bytes;
        int          nwr;
        logic        mem;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        err;
        int          nok;
    } vec_t;

    typedef struct packed {
        logic        s2;
        logic        s3;
        logic        iw;
        logic        dw;
        logic [8:0]  addr;
        logic [15:0] di;
        logic [15:0] dd;
    } ev_t;

    ev_t  evq[$];
    int   ok_cnt = 0;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] last_ins  = 16'h0000;
    logic [15:0] last_dram = 16'h0000;
    vec_t vecs[8];

    // Every cycle with a write-path enable is logged for later comparison.
    always @(negedge clock) begin
        if (start_2 || start_3)
            evq.push_back('{start_2, start_3, iram_write_ext, dram_write_ext,
                            addr_ext, Data_in_ins, Data_in_dram});
        if (load_ok)
            ok_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_gapped(input logic [63:0] bytes, input int nb);
        for (int i = 0; i < nb; i++) begin
            send(bytes[63-8*i -: 8]);
            idle(3);
        end
    endtask

    // Each write is a WR1 cycle with the strobe followed by a WR2 cycle without it.
    task automatic check_writes(input string name, input int base, input int nwr,
                                input logic mem, input logic [15:0] d0, input logic [15:0] d1);
        ev_t e;
        chk({name, " events"}, 64'(evq.size() - base), 64'(2 * nwr));
        for (int k = 0; k < nwr; k++) begin
            if (mem) last_dram = (k == 0) ? d0 : d1;
            else     last_ins  = (k == 0) ? d0 : d1;
            e = '{~mem, mem, ~mem, mem, 9'(k), last_ins, last_dram};
            if (base + 2*k + 1 < evq.size()) begin
                chk({name, " wr1"}, 64'(evq[base+2*k]), 64'(e));
                e.iw = 1'b0;
                e.dw = 1'b0;
                chk({name, " wr2"}, 64'(evq[base+2*k+1]), 64'(e));
            end
        end
    endtask

    function automatic logic [47:0] all_outs();
        return {start, start_2, start_3, iram_write_ext, dram_write_ext, addr_ext,
                Data_in_ins, Data_in_dram, busy, load_ok, error};
    endfunction

    initial begin
        int base;
        int okb;

        vecs[0] = '{8, 64'hA1_00_02_12_34_AB_CD_40, 2, 1'b0, 16'h1234, 16'hABCD, 1'b0, 1};
        vecs[1] = '{6, 64'hA2_00_01_BE_EF_00_00_00, 1, 1'b1, 16'hBEEF, 16'h0000, 1'b1, 0};
        vecs[2] = '{3, 64'hA1_02_01_00_00_00_00_00, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0};
        vecs[3] = '{1, 64'hA0_00_00_00_00_00_00_00, 0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0};
        vecs[4] = '{1, 64'h33_00_00_00_00_00_00_00, 0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0};
        vecs[5] = '{3, 64'hA2_00_00_00_00_00_00_00, 0, 1'b1, 16'h0000, 16'h0000, 1'b1, 0};
        vecs[6] = '{6, 64'hA1_00_01_00_05_05_00_00, 1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1};
        vecs[7] = '{8, 64'hA2_00_02_01_02_03_04_04, 2, 1'b1, 16'h0102, 16'h0304, 1'b0, 1};

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        idle(3);
        chk("reset outputs", 64'(all_outs()), 64'd0);
        reset_n = 1'b1;
        idle(1);

        for (int v = 0; v < 8; v++) begin
            base = evq.size();
            okb  = ok_cnt;
            send_gapped(vecs[v].bytes, vecs[v].nb);
            idle(2);
            check_writes($sformatf("vec%0d", v), base, vecs[v].nwr, vecs[v].mem,
                         vecs[v].d0, vecs[v].d1);
            chk($sformatf("vec%0d error", v), 64'(error), 64'(vecs[v].err));
            chk($sformatf("vec%0d load_ok", v), 64'(ok_cnt - okb), 64'(vecs[v].nok));
            chk($sformatf("vec%0d busy/start", v), 64'({busy, start}), 64'd0);
            $display("vec %0d: %0d bytes, %0d writes, error=%0b, load_ok=%0d",
                     v, vecs[v].nb, evq.size() - base, error, ok_cnt - okb);
        end
        chk("ins held", 64'(Data_in_ins), 64'h0005);
        chk("dram held", 64'(Data_in_dram), 64'h0304);

        chk("pre-run start", 64'(start), 64'd0);
        send(8'hA5);
        chk("run start", 64'({start, busy, start_2, start_3}), 64'b1000);
        idle(2);
        send(8'h77);
        chk("run bad byte", 64'({start, error}), 64'b11);
        send(8'hA0);
        chk("halt start", 64'({start, busy}), 64'b00);
        chk("halt keeps error", 64'(error), 64'd1);
        send(8'hA0);
        chk("idle halt clears", 64'(error), 64'd0);
        $display("run/halt sequence: start=%0b error=%0b", start, error);

        base = evq.size();
        okb  = ok_cnt;
        send_gapped(64'hA1_00_02_11_00_00_00_00, 4);
        send(8'h22);
        chk("wr1 strobe", 64'({start_2, iram_write_ext, addr_ext}), 64'({2'b11, 9'd0}));
        send(8'h99);
        chk("wr2 after byte", 64'({start_2, iram_write_ext, error, busy}), 64'b1011);
        idle(1);
        chk("abort to idle", 64'({start_2, busy}), 64'b00);
        check_writes("abort", base, 1, 1'b0, 16'h1122, 16'h0000);
        idle(2);
        chk("abort load_ok", 64'(ok_cnt - okb), 64'd0);
        send(8'hA0);
        chk("idle after abort", 64'(error), 64'd0);
        $display("mid-write byte: load abandoned, error raised");

        send_gapped(64'hA1_00_01_12_00_00_00_00, 4);
        chk("in data_lo", 64'(busy), 64'd1);
        reset_n = 1'b0;
        idle(1);
        chk("mid-load reset", 64'(all_outs()), 64'd0);
        reset_n   = 1'b1;
        last_ins  = 16'h0000;
        last_dram = 16'h0000;
        idle(1);
        base = evq.size();
        okb  = ok_cnt;
        send_gapped(64'hA1_00_01_00_05_05_00_00, 6);
        idle(2);
        check_writes("post-reset", base, 1, 1'b0, 16'h0005, 16'h0000);
        chk("post-reset ok", 64'({ok_cnt - okb, 1'(error)}), 64'({32'd1, 1'b0}));
        $display("mid-load reset: reload wrote %0d events", evq.size() - base);

        send_gapped(64'hA1_02_00_00_00_00_00_00, 3);
        chk("len 512 accepted", 64'({busy, error}), 64'b10);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        idle(1);
        chk("len 512 reset", 64'(busy), 64'd0);
        $display("length 512 accepted, cleared by reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
